// File: rtl/face_det_pkg.sv
// Shared coordinate widths, screen limits, controller state encoding and box type
// for the face-detect overlay path.
package face_det_pkg;

    localparam int DEF_HCNT_W = 11;
    localparam int DEF_VCNT_W = 11;
    localparam int DEF_H_MAX  = 799;
    localparam int DEF_V_MAX  = 599;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_HOLD    = 2'd3
    } ovl_state_t;

    typedef struct packed {
        logic [DEF_HCNT_W-1:0] x0;
        logic [DEF_VCNT_W-1:0] y0;
        logic [DEF_HCNT_W-1:0] x1;
        logic [DEF_VCNT_W-1:0] y1;
    } box_t;

endpackage

// File: rtl/rect_box_filter.sv
// One axis of the box path: orders and clamps a raw corner pair, and forms the
// rounded average of the shown pair with the pending pair.
module rect_box_filter #(
    parameter int W   = 11,
    parameter int MAX = 799
) (
    input  logic [W-1:0] raw_a_i,
    input  logic [W-1:0] raw_b_i,
    input  logic [W-1:0] old_lo_i,
    input  logic [W-1:0] old_hi_i,
    input  logic [W-1:0] new_lo_i,
    input  logic [W-1:0] new_hi_i,
    output logic [W-1:0] san_lo_o,
    output logic [W-1:0] san_hi_o,
    output logic [W-1:0] avg_lo_o,
    output logic [W-1:0] avg_hi_o
);

    localparam logic [W-1:0] MAX_L = W'(MAX);

    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [W:0]   sum_lo;
    logic [W:0]   sum_hi;

    assign lo = (raw_a_i <= raw_b_i) ? raw_a_i : raw_b_i;
    assign hi = (raw_a_i <= raw_b_i) ? raw_b_i : raw_a_i;

    assign san_lo_o = (lo > MAX_L) ? MAX_L : lo;
    assign san_hi_o = (hi > MAX_L) ? MAX_L : hi;

    // Extra bit keeps the carry; dropping the LSB gives a round-half-up average.
    assign sum_lo = {1'b0, old_lo_i} + {1'b0, new_lo_i} + {{W{1'b0}}, 1'b1};
    assign sum_hi = {1'b0, old_hi_i} + {1'b0, new_hi_i} + {{W{1'b0}}, 1'b1};

    assign avg_lo_o = sum_lo[W:1];
    assign avg_hi_o = sum_hi[W:1];

endmodule

// File: rtl/rect_overlay_ctrl.sv
// Frame-rate controller between the face detector and draw_rectangle: confirms,
// smooths and holds detector boxes, updating the shown rectangle only at frame ticks.
module rect_overlay_ctrl
    import face_det_pkg::*;
#(
    parameter int HCNT_W         = DEF_HCNT_W,
    parameter int VCNT_W         = DEF_VCNT_W,
    parameter int H_MAX          = DEF_H_MAX,
    parameter int V_MAX          = DEF_V_MAX,
    parameter int CONFIRM_FRAMES = 2,
    parameter int HOLD_FRAMES    = 8,
    parameter int CONT_FRAMES    = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vblnk_in,
    input  logic              det_valid,
    output logic              det_ready,
    input  logic              det_found,
    input  logic [HCNT_W-1:0] det_x0,
    input  logic [HCNT_W-1:0] det_x1,
    input  logic [VCNT_W-1:0] det_y0,
    input  logic [VCNT_W-1:0] det_y1,
    output logic [HCNT_W-1:0] rect_x0,
    output logic [HCNT_W-1:0] rect_x1,
    output logic [VCNT_W-1:0] rect_y0,
    output logic [VCNT_W-1:0] rect_y1,
    output logic              rect_en,
    output logic              detected_flag,
    output logic              continuous
);

    localparam int HITS_W = $clog2(CONFIRM_FRAMES + 1);
    localparam int MISS_W = $clog2(HOLD_FRAMES + 1);
    localparam int RUN_W  = $clog2(CONT_FRAMES + 1);

    localparam logic [HITS_W-1:0] CONFIRM_LAST = HITS_W'(CONFIRM_FRAMES - 1);
    localparam logic [MISS_W-1:0] HOLD_LAST    = MISS_W'(HOLD_FRAMES - 1);
    localparam logic [RUN_W-1:0]  CONT_LAST    = RUN_W'(CONT_FRAMES - 1);
    localparam logic [RUN_W-1:0]  RUN_MAX      = RUN_W'(CONT_FRAMES);

    logic              vblnk_q, tick_q, rdy_q;
    logic              pend_v_q, pend_found_q;
    logic [HCNT_W-1:0] pend_x0_q, pend_x1_q;
    logic [VCNT_W-1:0] pend_y0_q, pend_y1_q;

    ovl_state_t        state_q;
    logic [HITS_W-1:0] hits_q;
    logic [MISS_W-1:0] miss_q;
    logic [RUN_W-1:0]  run_q;
    logic [HCNT_W-1:0] rect_x0_q, rect_x1_q;
    logic [VCNT_W-1:0] rect_y0_q, rect_y1_q;
    logic              rect_en_q, det_flag_q, cont_q;

    logic              xfer, frame_found;
    logic [HCNT_W-1:0] san_x0, san_x1, avg_x0, avg_x1;
    logic [VCNT_W-1:0] san_y0, san_y1, avg_y0, avg_y1;

    rect_box_filter #(.W(HCNT_W), .MAX(H_MAX)) u_filt_x (
        .raw_a_i (det_x0),    .raw_b_i (det_x1),
        .old_lo_i(rect_x0_q), .old_hi_i(rect_x1_q),
        .new_lo_i(pend_x0_q), .new_hi_i(pend_x1_q),
        .san_lo_o(san_x0),    .san_hi_o(san_x1),
        .avg_lo_o(avg_x0),    .avg_hi_o(avg_x1)
    );

    rect_box_filter #(.W(VCNT_W), .MAX(V_MAX)) u_filt_y (
        .raw_a_i (det_y0),    .raw_b_i (det_y1),
        .old_lo_i(rect_y0_q), .old_hi_i(rect_y1_q),
        .new_lo_i(pend_y0_q), .new_hi_i(pend_y1_q),
        .san_lo_o(san_y0),    .san_hi_o(san_y1),
        .avg_lo_o(avg_y0),    .avg_hi_o(avg_y1)
    );

    assign det_ready   = rdy_q & ~tick_q;
    assign xfer        = det_valid & det_ready;
    assign frame_found = pend_v_q & pend_found_q;

    // vblnk_q resets high so a blank already in progress at reset release is not a tick.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vblnk_q      <= 1'b1;
            tick_q       <= 1'b0;
            rdy_q        <= 1'b0;
            pend_v_q     <= 1'b0;
            pend_found_q <= 1'b0;
            pend_x0_q    <= '0;
            pend_x1_q    <= '0;
            pend_y0_q    <= '0;
            pend_y1_q    <= '0;
        end else begin
            vblnk_q <= vblnk_in;
            tick_q  <= vblnk_in & ~vblnk_q;
            rdy_q   <= 1'b1;
            if (tick_q) begin
                pend_v_q <= 1'b0;
            end else if (xfer) begin
                pend_v_q     <= 1'b1;
                pend_found_q <= det_found;
                pend_x0_q    <= san_x0;
                pend_x1_q    <= san_x1;
                pend_y0_q    <= san_y0;
                pend_y1_q    <= san_y1;
            end
        end
    end

    // Counters idle at zero outside their state, so one compare serves both entry paths.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hits_q     <= '0;
            miss_q     <= '0;
            run_q      <= '0;
            rect_x0_q  <= '0;
            rect_x1_q  <= '0;
            rect_y0_q  <= '0;
            rect_y1_q  <= '0;
            rect_en_q  <= 1'b0;
            det_flag_q <= 1'b0;
            cont_q     <= 1'b0;
        end else if (tick_q) begin
            case (state_q)
                ST_IDLE, ST_ACQUIRE: begin
                    if (!frame_found) begin
                        state_q <= ST_IDLE;
                        hits_q  <= '0;
                    end else if (hits_q == CONFIRM_LAST) begin
                        state_q    <= ST_TRACK;
                        hits_q     <= '0;
                        run_q      <= RUN_W'(1);
                        rect_x0_q  <= pend_x0_q;
                        rect_x1_q  <= pend_x1_q;
                        rect_y0_q  <= pend_y0_q;
                        rect_y1_q  <= pend_y1_q;
                        rect_en_q  <= 1'b1;
                        det_flag_q <= 1'b1;
                        cont_q     <= (CONT_FRAMES == 1);
                    end else begin
                        state_q <= ST_ACQUIRE;
                        hits_q  <= hits_q + 1'b1;
                    end
                end
                ST_TRACK, ST_HOLD: begin
                    if (frame_found) begin
                        state_q    <= ST_TRACK;
                        miss_q     <= '0;
                        rect_x0_q  <= avg_x0;
                        rect_x1_q  <= avg_x1;
                        rect_y0_q  <= avg_y0;
                        rect_y1_q  <= avg_y1;
                        det_flag_q <= 1'b1;
                        cont_q     <= (run_q >= CONT_LAST);
                        if (run_q != RUN_MAX) run_q <= run_q + 1'b1;
                    end else begin
                        run_q      <= '0;
                        det_flag_q <= 1'b0;
                        cont_q     <= 1'b0;
                        if (miss_q == HOLD_LAST) begin
                            state_q   <= ST_IDLE;
                            miss_q    <= '0;
                            rect_en_q <= 1'b0;
                        end else begin
                            state_q <= ST_HOLD;
                            miss_q  <= miss_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rect_x0       = rect_x0_q;
    assign rect_x1       = rect_x1_q;
    assign rect_y0       = rect_y0_q;
    assign rect_y1       = rect_y1_q;
    assign rect_en       = rect_en_q;
    assign detected_flag = det_flag_q;
    assign continuous    = cont_q;

endmodule

// File: tb/tb_rect_overlay_ctrl.sv
// Bench for rect_overlay_ctrl: directed frame table, hand-built tick/reset corner
// sequences, then random frames against a frame-level reference model.
module tb_rect_overlay_ctrl;

    logic        pclk = 1'b0;
    logic        rst, vblnk_in, det_valid, det_found, det_ready;
    logic [10:0] det_x0, det_x1, det_y0, det_y1;
    logic [10:0] rect_x0, rect_x1, rect_y0, rect_y1;
    logic        rect_en, detected_flag, continuous;

    int checks = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    rect_overlay_ctrl dut (
        .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in),
        .det_valid(det_valid), .det_ready(det_ready), .det_found(det_found),
        .det_x0(det_x0), .det_x1(det_x1), .det_y0(det_y0), .det_y1(det_y1),
        .rect_x0(rect_x0), .rect_x1(rect_x1), .rect_y0(rect_y0), .rect_y1(rect_y1),
        .rect_en(rect_en), .detected_flag(detected_flag), .continuous(continuous)
    );

    typedef struct {
        int nDet; bit found; int x0, y0, x1, y1;
        bit en, det, cont; int rx0, ry0, rx1, ry1;
    } vec_t;

    vec_t vecs[19];

    // Frame-level reference: shown/confirmed rectangle described by streaks, not states.
    bit mShown, mDet;
    int mStreak, mMiss, mRun;
    int mr[4];

    function automatic vec_t mkVec(int nDet, bit found, int x0, int y0, int x1, int y1,
                                   bit en, bit det, bit cont, int rx0, int ry0, int rx1, int ry1);
        vec_t v;
        v.nDet = nDet; v.found = found; v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1;
        v.en = en; v.det = det; v.cont = cont; v.rx0 = rx0; v.ry0 = ry0; v.rx1 = rx1; v.ry1 = ry1;
        return v;
    endfunction

    function automatic int sanLo(int a, int b, int mx);
        int v;
        v = (a < b) ? a : b;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int sanHi(int a, int b, int mx);
        int v;
        v = (a > b) ? a : b;
        return (v > mx) ? mx : v;
    endfunction

    task automatic modelReset();
        mShown = 0; mDet = 0; mStreak = 0; mMiss = 0; mRun = 0;
        for (int i = 0; i < 4; i++) mr[i] = 0;
    endtask

    task automatic modelFrame(bit f, int s0, int s1, int s2, int s3);
        int s[4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        if (!mShown) begin
            if (f) begin
                mStreak++;
                if (mStreak >= 2) begin
                    mShown = 1; mDet = 1; mRun = 1; mMiss = 0; mStreak = 0;
                    for (int i = 0; i < 4; i++) mr[i] = s[i];
                end
            end else begin
                mStreak = 0;
            end
        end else if (f) begin
            for (int i = 0; i < 4; i++) mr[i] = (mr[i] + s[i] + 1) / 2;
            mRun++;
            mMiss = 0;
            mDet = 1;
        end else begin
            mMiss++;
            mRun = 0;
            mDet = 0;
            if (mMiss == 8) begin
                mShown = 0;
                mStreak = 0;
                mMiss = 0;
            end
        end
    endtask

    task automatic checkVal(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic checkOutput(string tag, bit en, bit det, bit cont,
                               int rx0, int ry0, int rx1, int ry1);
        @(negedge pclk);
        checkVal({tag, ".rect_en"}, int'(rect_en), int'(en));
        checkVal({tag, ".detected_flag"}, int'(detected_flag), int'(det));
        checkVal({tag, ".continuous"}, int'(continuous), int'(cont));
        checkVal({tag, ".rect_x0"}, int'(rect_x0), rx0);
        checkVal({tag, ".rect_y0"}, int'(rect_y0), ry0);
        checkVal({tag, ".rect_x1"}, int'(rect_x1), rx1);
        checkVal({tag, ".rect_y1"}, int'(rect_y1), ry1);
    endtask

    task automatic doTransfer(bit found, int x0, int y0, int x1, int y1);
        bit got;
        got = 0;
        det_valid = 1; det_found = found;
        det_x0 = 11'(x0); det_y0 = 11'(y0); det_x1 = 11'(x1); det_y1 = 11'(y1);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge pclk);
            if (det_ready) begin
                @(posedge pclk);
                #1;
                got = 1;
            end
        end
        det_valid = 0;
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL handshake_timeout got ready=0 expected ready=1");
        end
    endtask

    task automatic doTick();
        vblnk_in = 1;
        repeat (3) @(posedge pclk);
        #1 vblnk_in = 0;
        repeat (2) @(posedge pclk);
        #1;
    endtask

    task automatic applyStimulus(vec_t v);
        if (v.nDet > 0) doTransfer(v.found, v.x0, v.y0, v.x1, v.y1);
        doTick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lowCount;
        vecs[0]  = mkVec(1, 1, 100,  50, 200, 150, 0, 0, 0,   0,   0,   0,   0);
        vecs[1]  = mkVec(1, 1, 100,  50, 200, 150, 1, 1, 0, 100,  50, 200, 150);
        vecs[2]  = mkVec(1, 1, 110,  60, 210, 160, 1, 1, 0, 105,  55, 205, 155);
        for (int i = 3; i <= 9; i++)
            vecs[i] = mkVec(0, 0, 0, 0, 0, 0, 1, 0, 0, 105, 55, 205, 155);
        vecs[10] = mkVec(0, 0,   0,   0,   0,   0, 0, 0, 0, 105,  55, 205, 155);
        vecs[11] = mkVec(1, 0,   1,   2,   3,   4, 0, 0, 0, 105,  55, 205, 155);
        vecs[12] = mkVec(1, 1, 300, 900, 250,  40, 0, 0, 0, 105,  55, 205, 155);
        vecs[13] = mkVec(1, 1, 300, 900, 250,  40, 1, 1, 0, 250,  40, 300, 599);
        vecs[14] = mkVec(1, 1, 250,  40, 250,  40, 1, 1, 0, 250,  40, 275, 320);
        vecs[15] = mkVec(0, 0,   0,   0,   0,   0, 1, 0, 0, 250,  40, 275, 320);
        vecs[16] = mkVec(0, 0,   0,   0,   0,   0, 1, 0, 0, 250,  40, 275, 320);
        vecs[17] = mkVec(0, 0,   0,   0,   0,   0, 1, 0, 0, 250,  40, 275, 320);
        vecs[18] = mkVec(1, 1, 250,  40, 275, 320, 1, 1, 0, 250,  40, 275, 320);

        rst = 1; vblnk_in = 1; det_valid = 0; det_found = 0;
        det_x0 = 0; det_x1 = 0; det_y0 = 0; det_y1 = 0;
        repeat (3) @(posedge pclk);
        #1 rst = 0;
        @(posedge pclk);
        #1;
        lowCount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            if (!det_ready) lowCount++;
        end
        checkVal("reset.ready_low_cycles", lowCount, 0);
        checkOutput("reset", 0, 0, 0, 0, 0, 0, 0);
        vblnk_in = 0;
        @(posedge pclk);
        #1;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].en, vecs[i].det, vecs[i].cont,
                        vecs[i].rx0, vecs[i].ry0, vecs[i].rx1, vecs[i].ry1);
        end

        for (int k = 1; k <= 16; k++) begin
            doTransfer(1, 250, 40, 275, 320);
            doTick();
            checkOutput($sformatf("cont%0d", k), 1, 1, (k >= 15), 250, 40, 275, 320);
        end
        doTick();
        checkOutput("cont_drop", 1, 0, 0, 250, 40, 275, 320);

        doTransfer(1, 10, 10, 20, 20);
        doTransfer(1, 250, 40, 275, 320);
        doTick();
        checkOutput("last_wins", 1, 1, 0, 250, 40, 275, 320);

        // det_valid raised in the tick cycle must wait and land in the following frame.
        vblnk_in = 1;
        @(posedge pclk);
        #1;
        det_valid = 1; det_found = 1;
        det_x0 = 11'd250; det_y0 = 11'd40; det_x1 = 11'd275; det_y1 = 11'd320;
        @(negedge pclk);
        checkVal("held.ready_in_tick", int'(det_ready), 0);
        @(posedge pclk);
        #1;
        @(negedge pclk);
        checkVal("held.ready_after_tick", int'(det_ready), 1);
        @(posedge pclk);
        #1;
        det_valid = 0;
        vblnk_in = 0;
        repeat (2) @(posedge pclk);
        #1;
        checkOutput("held_hold", 1, 0, 0, 250, 40, 275, 320);
        doTick();
        checkOutput("held_track", 1, 1, 0, 250, 40, 275, 320);

        doTransfer(1, 5, 5, 9, 9);
        rst = 1;
        @(posedge pclk);
        #1 rst = 0;
        checkOutput("midrst", 0, 0, 0, 0, 0, 0, 0);
        doTick();
        checkOutput("midrst_f1", 0, 0, 0, 0, 0, 0, 0);
        doTransfer(1, 5, 5, 9, 9);
        doTick();
        checkOutput("midrst_f2", 0, 0, 0, 0, 0, 0, 0);

        rst = 1;
        @(posedge pclk);
        #1 rst = 0;
        modelReset();
        for (int fr = 0; fr < 80; fr++) begin
            int nd, r, a, b, c, d;
            bit f, rf;
            int s[4];
            r = $urandom_range(0, 5);
            nd = (r == 0) ? 0 : ((r == 5) ? 2 : 1);
            f = 0;
            for (int i = 0; i < 4; i++) s[i] = 0;
            for (int k = 0; k < nd; k++) begin
                rf = ($urandom_range(0, 9) != 0);
                a = $urandom_range(0, 1023); b = $urandom_range(0, 1023);
                c = $urandom_range(0, 1023); d = $urandom_range(0, 1023);
                doTransfer(rf, a, b, c, d);
                f = rf;
                s[0] = sanLo(a, c, 799); s[2] = sanHi(a, c, 799);
                s[1] = sanLo(b, d, 599); s[3] = sanHi(b, d, 599);
            end
            doTick();
            modelFrame(f, s[0], s[1], s[2], s[3]);
            checkOutput($sformatf("rand%0d", fr), mShown, mDet, (mDet && mRun >= 16),
                        mr[0], mr[1], mr[2], mr[3]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
